// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 2:1 stream demultiplexer.
// Channel indices, buffer depth, default widths and buffer occupancy states.
package stream_demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEPTH         = 2;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry valid/ready buffer with no bypass. The head word sits in a register
// that reads as zero when the buffer is empty.
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_e             occ_r, occ_s;
  logic [WIDTH-1:0] head_r, head_s;
  logic [WIDTH-1:0] tail_r, tail_s;
  logic             valid_r, valid_s;
  logic             full_r, full_s;
  logic             pop_s;

  assign pop_s = valid_r & out_ready;

  // Next occupancy and entry contents; push is never asserted while full.
  always_comb begin
    occ_s  = occ_r;
    head_s = head_r;
    tail_s = tail_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (push) begin
          head_s = push_data;
          occ_s  = OCC_ONE;
        end else begin
          occ_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push && pop_s) begin
          head_s = push_data;
        end else if (push) begin
          tail_s = push_data;
          occ_s  = OCC_FULL;
        end else if (pop_s) begin
          head_s = {WIDTH{1'b0}};
          occ_s  = OCC_EMPTY;
        end else begin
          occ_s  = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (pop_s) begin
          head_s = tail_r;
          tail_s = {WIDTH{1'b0}};
          occ_s  = OCC_ONE;
        end else begin
          occ_s  = OCC_FULL;
        end
      end
      default: begin
        occ_s  = OCC_EMPTY;
        head_s = {WIDTH{1'b0}};
        tail_s = {WIDTH{1'b0}};
      end
    endcase
    valid_s = (occ_s != OCC_EMPTY);
    full_s  = (occ_s == OCC_FULL);
  end

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      occ_r   <= occ_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
      valid_r <= valid_s;
      full_r  <= full_s;
    end
  end

  assign out_data  = head_r;
  assign out_valid = valid_r;
  assign full      = full_r;

endmodule

// File: rtl/stream_demux.sv
// Receive side of the shared 2:1 link: steers each tagged word into one of two
// buffered valid/ready channels and counts delivered words per channel.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             full0_s, full1_s;
  logic             push0_s, push1_s;
  logic [CNT_W-1:0] cnt0_r, cnt0_s;
  logic [CNT_W-1:0] cnt1_r, cnt1_s;

  // Only the selected channel's registered full flag gates acceptance.
  assign in_ready = ((in_sel == CH1) ? ~full1_s : ~full0_s) & ~rst;
  assign push0_s  = in_valid & in_ready & (in_sel == CH0);
  assign push1_s  = in_valid & in_ready & (in_sel == CH1);

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0_s),
    .push_data (in_data),
    .full      (full0_s),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready)
  );

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_s),
    .push_data (in_data),
    .full      (full1_s),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready)
  );

  // Saturating delivery counters advance on each output handshake.
  always_comb begin
    cnt0_s = cnt0_r;
    cnt1_s = cnt1_r;
    if (out0_valid && out0_ready && (cnt0_r != CNT_MAX)) begin
      cnt0_s = cnt0_r + CNT_ONE;
    end else begin
      cnt0_s = cnt0_r;
    end
    if (out1_valid && out1_ready && (cnt1_r != CNT_MAX)) begin
      cnt1_s = cnt1_r + CNT_ONE;
    end else begin
      cnt1_s = cnt1_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      cnt0_r <= cnt0_s;
      cnt1_r <= cnt1_s;
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_stream_demux;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int total;
  int bad;

  stream_demux #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         sel;
    logic [W-1:0] d;
    logic         r0;
    logic         r1;
    logic         er;
    logic         ev0;
    logic [W-1:0] ed0;
    logic         ev1;
    logic [W-1:0] ed1;
    logic [CW-1:0] ec0;
    logic [CW-1:0] ec1;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = 4'h0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int c0, c1;
  logic exp_rdy;

  initial begin
    total = 0;
    bad   = 0;

    // Reset state, with a word offered so in_ready would otherwise be 1.
    idle_inputs();
    rst = 1'b1;
    in_valid = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    tick();
    do_reset();

    // Routing and backpressure vectors.
    tbl[0] = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 2'd0, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hA, 2'd1, 2'd0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd1, 2'd1};
    tbl[3] = '{1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC, 1'b0, 4'h0, 2'd1, 2'd1};
    tbl[4] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC, 1'b0, 4'h0, 2'd1, 2'd1};
    tbl[5] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 4'h0, 2'd1, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 2'd2, 2'd1};
    tbl[7] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 2'd3, 2'd1};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd3, 2'd1};
    for (int i = 0; i < 9; i++) begin
      in_valid   = tbl[i].v;
      in_sel     = tbl[i].sel;
      in_data    = tbl[i].d;
      out0_ready = tbl[i].r0;
      out1_ready = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].er);
      tick();
      chk($sformatf("vec%0d_out0_valid", i), out0_valid, tbl[i].ev0);
      chk($sformatf("vec%0d_out0_data", i), out0_data, tbl[i].ed0);
      chk($sformatf("vec%0d_out1_valid", i), out1_valid, tbl[i].ev1);
      chk($sformatf("vec%0d_out1_data", i), out1_data, tbl[i].ed1);
      chk($sformatf("vec%0d_cnt0", i), cnt0, tbl[i].ec0);
      chk($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].ec1);
    end

    // Channel isolation: full channel 1 must not block channel 0.
    do_reset();
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h9;
    #1 chk("iso_first_rdy", in_ready, 1);
    tick();
    in_data = 4'h7;
    #1 chk("iso_second_rdy", in_ready, 1);
    tick();
    #1 chk("iso_ch1_full_rdy", in_ready, 0);
    in_sel = 1'b0; in_data = 4'h6;
    #1 chk("iso_ch0_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("iso_out0_valid", out0_valid, 1);
    chk("iso_out0_data", out0_data, 4'h6);
    chk("iso_out1_data", out1_data, 4'h9);
    tick();
    chk("iso_out1_hold", out1_data, 4'h9);
    chk("iso_out1_valid_hold", out1_valid, 1);
    chk("iso_cnt0", cnt0, 1);
    chk("iso_cnt1", cnt1, 0);

    // Sustained push/pop on channel 1 at occupancy 1.
    do_reset();
    out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = 4'(i + 1);
      #1 chk($sformatf("thr%0d_rdy", i), in_ready, 1);
      tick();
      chk($sformatf("thr%0d_valid", i), out1_valid, 1);
      chk($sformatf("thr%0d_data", i), out1_data, i + 1);
    end
    in_valid = 1'b0;
    tick();
    chk("thr_drained", out1_valid, 0);
    chk("thr_cnt1", cnt1, sat(8));

    // Counter saturation on channel 0.
    do_reset();
    out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 4'(i);
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("sat%0d_cnt0", i), cnt0, sat(i + 1));
      chk($sformatf("sat%0d_cnt1", i), cnt1, 0);
    end

    // Reset asserted between edges while channel 0 holds two words.
    do_reset();
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h2;
    tick();
    in_valid = 1'b0;
    tick();
    out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h4;
    tick();
    in_data = 4'h8;
    tick();
    in_valid = 1'b0;
    #1 chk("mid_full_rdy", in_ready, 0);
    chk("mid_pre_cnt0", cnt0, 1);
    in_valid = 1'b1; in_data = 4'h1;
    #1 rst = 1'b1;
    #1;
    chk("mid_out0_valid", out0_valid, 0);
    chk("mid_out0_data", out0_data, 0);
    chk("mid_cnt0", cnt0, 0);
    chk("mid_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out0_ready = 1'b1;
    tick();
    chk("mid_after_valid", out0_valid, 0);
    chk("mid_after_cnt0", cnt0, 0);

    // Randomized traffic against a queue model.
    do_reset();
    q0.delete(); q1.delete();
    c0 = 0; c1 = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = 4'($urandom_range(0, 15));
      out0_ready = ($urandom_range(0, 9) < 6);
      out1_ready = ($urandom_range(0, 9) < 4);
      exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
      #1 chk("rnd_in_ready", in_ready, exp_rdy);
      if (q0.size() > 0 && out0_ready) begin
        void'(q0.pop_front());
        c0 = sat(c0 + 1);
      end
      if (q1.size() > 0 && out1_ready) begin
        void'(q1.pop_front());
        c1 = sat(c1 + 1);
      end
      if (in_valid && exp_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      tick();
      chk("rnd_out0_valid", out0_valid, q0.size() > 0);
      chk("rnd_out0_data", out0_data, (q0.size() > 0) ? q0[0] : 4'h0);
      chk("rnd_out1_valid", out1_valid, q1.size() > 0);
      chk("rnd_out1_data", out1_data, (q1.size() > 0) ? q1[0] : 4'h0);
      chk("rnd_cnt0", cnt0, c0);
      chk("rnd_cnt1", cnt1, c1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Receive end of the shared 2:1 multiplexed datapath: takes one WIDTH-bit stream tagged with a select bit and routes each word to channel 0 or channel 1.
- Each channel has a 2-entry buffer with valid/ready output handshake, so one stalled consumer does not corrupt the other.
- Sits after the Multiplexer stage on the shared link. Provides per-channel saturating delivery counters for debug.

Parameters:
- WIDTH, 4, data width of input word and of each output channel.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word on the shared link.
- in_sel  input  1  destination: 0 to channel 0, 1 to channel 1.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  channel 0 head word.
- out0_valid  output  1  channel 0 head word is valid.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.
- out1_valid  output  1  channel 1 head word is valid.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words delivered on channel 0, saturating.
- cnt1  output  CNT_W  words delivered on channel 1, saturating.

Behaviour:
- Reset is asynchronous and active-high: all state clears immediately on rst=1, independent of clk.
  - Both buffers empty; outN_valid=0, outN_data=0, cnt0=cnt1=0.
  - in_ready=0 while rst=1.
  - First acceptance is possible on the first clk edge after rst deasserts.
- Input transfer occurs when in_valid && in_ready at the rising edge.
- in_ready is (in_sel ? !full1 : !full0) && !rst, combinational from in_sel.
  - It depends only on the selected channel, so a full channel 1 never blocks a word for channel 0.
- Each channel buffer:
  - 2-entry FIFO holding WIDTH bits per entry, with occupancy 0..2.
  - full = (occupancy==2).
  - No bypass: an accepted word appears on outN_data with outN_valid=1 on the cycle after acceptance (1-cycle latency).
- Output transfer on channel N occurs when outN_valid && outN_ready at the edge. The head then advances to the next entry, or valid drops if the buffer is now empty.
- outN_data is held stable while outN_valid=1 and outN_ready=0.
- outN_data returns to 0 when the buffer is empty.
- Simultaneous push and pop on the same channel:
  - occupancy 1: stays 1; the new word becomes head next cycle.
  - occupancy 0: push only, because valid is 0.
  - occupancy 2: push not allowed. in_ready is 0 even if the pop happens this cycle; no full-bypass.
- Ordering within a channel is strictly FIFO. There is no ordering guarantee between channels.
- cntN increments by 1 on each output transfer on channel N and saturates at 2^CNT_W-1 (no wrap).
- Only registered state plus the in_ready logic: no combinational path from outN_ready to in_ready.
- Reset asserted mid-operation discards buffered words. Counters clear. No partial transfer is completed.
- in_sel and in_data are ignored when in_valid=0.

Decomposition:
- Shared package holds:
  - channel index constants CH0=0, CH1=1;
  - buffer depth constant DEPTH=2;
  - default widths WIDTH=4, CNT_W=8.
- One sub-module, demux_fifo2:
  - 2-entry valid/ready FIFO parameterised by WIDTH;
  - ports clk, rst, push, push_data, full, out_data, out_valid, out_ready.
- stream_demux instantiates demux_fifo2 twice and adds the select steering and the two saturating counters.

Test Plan:
- Reset mid-traffic: load channel 0 with 2 words, assert rst between clock edges -> out0_valid=0, cnt0=0, in_ready=0 immediately, before the next edge.
- Basic routing, WIDTH=4, both readies=1:
  - sel=0 data=0011, then sel=1 data=1010 -> out0 shows 0011 one cycle after acceptance, out1 shows 1010 one cycle later;
  - cnt0=1, cnt1=1.
- Backpressure and FIFO order: out0_ready=0; push 1100, 0101, 1111 all with sel=0:
  - first two accepted; third sees in_ready=0;
  - raise out0_ready -> 1100 then 0101 delivered in order, then 1111 accepted.
- Channel isolation: channel 1 full with out1_ready=0; present sel=0 data=0110 -> in_ready=1 and word delivered on out0 next cycle; out1_data held stable.
- Simultaneous push/pop at occupancy 1: sustained in_valid=1 sel=1 with out1_ready=1 -> one word per cycle throughput; occupancy stays 1; no drops, verified by count and order.
- Counter saturation, CNT_W=2: deliver 5 words on channel 0 -> cnt0 reads 1, 2, 3, 3, 3; cnt1 stays 0.
